// File: rtl/fram_bist_sequencer.sv
// fram_bist_sequencer: LFSR write/readback self-test of an FM24CLxx FRAM
// through axil_master. Define FRAM_BIST_TIMEOUT_EN for a transfer timeout.
module fram_bist_sequencer #(
  parameter int          FM24CLXX_TYPE = 2048,
  parameter int          START_ADDR    = 0,
  parameter int          WORD_COUNT    = 16,
  parameter logic [31:0] SEED          = 32'h0000_0001,
  parameter int          TIMEOUT_CYC   = 65535,
  localparam int         ADDR_W        = $clog2(FM24CLXX_TYPE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bist_go,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
`ifdef FRAM_BIST_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              start,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       data_in,
  output logic              write_enable,
  output logic              read_enable,
  input  logic              busy,
  input  logic [31:0]       data_out
);

  localparam int IDX_W =
    (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(WORD_COUNT - 1);
  localparam logic [31:0] SEED_EFF =
    (SEED == 32'd0) ? 32'd1 : SEED;

  if (START_ADDR % 4 != 0 || WORD_COUNT < 1 ||
      WORD_COUNT > FM24CLXX_TYPE / 4 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
  begin : g_bad_cfg
    $error("fram_bist_sequencer: bad parameters");
  end

  typedef enum logic [3:0] {
    IDLE, WR_ISSUE, WR_ACK, WR_WAIT,
    RD_ISSUE, RD_ACK, RD_WAIT, CHECK, DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      lfsr;
  logic [31:0]      rd_data;

  // Window wraps because the sum is truncated to ADDR_W bits.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [IDX_W-1:0] i
  );
    logic [31:0] s;
    s = 32'(START_ADDR) + (32'(i) << 2);
    return s[ADDR_W-1:0];
  endfunction

  logic [31:0]       lfsr_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [ADDR_W-1:0] addr_0;
  logic [15:0]       err_inc;
  logic              mismatch;
  logic              last;

  assign lfsr_nx  = {lfsr[30:0],
                     lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign addr_nx  = word_addr(idx + 1'b1);
  assign addr_0   = word_addr('0);
  assign err_inc  = (err_count == 16'hFFFF) ?
                    err_count : err_count + 16'd1;
  assign mismatch = rd_data != lfsr;
  assign last     = idx == LAST;

`ifdef FRAM_BIST_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        wait_st;
  logic        moving;
  logic        tmo_hit;

  assign wait_st = state inside {WR_ACK, WR_WAIT,
                                 RD_ACK, RD_WAIT};
  assign moving  = (state inside {WR_ACK, RD_ACK}) ?
                   busy : !busy;
  assign tmo_hit = tmo_cnt == 16'(TIMEOUT_CYC - 1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      idx            <= '0;
      lfsr           <= SEED_EFF;
      rd_data        <= '0;
      bist_busy      <= 1'b0;
      bist_done      <= 1'b0;
      bist_pass      <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      start          <= 1'b0;
      mem_address    <= '0;
      data_in        <= '0;
      write_enable   <= 1'b0;
      read_enable    <= 1'b0;
`ifdef FRAM_BIST_TIMEOUT_EN
      tmo_cnt        <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE: if (bist_go) begin
          state          <= WR_ISSUE;
          bist_busy      <= 1'b1;
          bist_done      <= 1'b0;
          bist_pass      <= 1'b0;
          err_count      <= '0;
          first_err_addr <= '0;
          idx            <= '0;
          lfsr           <= SEED_EFF;
          start          <= 1'b1;
          write_enable   <= 1'b1;
          mem_address    <= addr_0;
          data_in        <= SEED_EFF;
`ifdef FRAM_BIST_TIMEOUT_EN
          timeout_err    <= 1'b0;
`endif
        end
        WR_ISSUE: state <= WR_ACK;
        WR_ACK: if (busy) state <= WR_WAIT;
        WR_WAIT: if (!busy) begin
          start <= 1'b1;
          if (last) begin
            state        <= RD_ISSUE;
            idx          <= '0;
            lfsr         <= SEED_EFF;
            write_enable <= 1'b0;
            read_enable  <= 1'b1;
            mem_address  <= addr_0;
            data_in      <= SEED_EFF;
          end else begin
            state       <= WR_ISSUE;
            idx         <= idx + 1'b1;
            lfsr        <= lfsr_nx;
            mem_address <= addr_nx;
            data_in     <= lfsr_nx;
          end
        end
        RD_ISSUE: state <= RD_ACK;
        RD_ACK: if (busy) state <= RD_WAIT;
        RD_WAIT: if (!busy) begin
          state       <= CHECK;
          rd_data     <= data_out;
          read_enable <= 1'b0;
        end
        CHECK: begin
          lfsr <= lfsr_nx;
          if (mismatch) begin
            err_count <= err_inc;
            if (err_count == 16'd0)
              first_err_addr <= mem_address;
          end
          if (last) begin
            state     <= DONE;
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            bist_pass <= !mismatch &&
                         err_count == 16'd0;
          end else begin
            state       <= RD_ISSUE;
            idx         <= idx + 1'b1;
            start       <= 1'b1;
            read_enable <= 1'b1;
            mem_address <= addr_nx;
            data_in     <= lfsr_nx;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef FRAM_BIST_TIMEOUT_EN
      // A stalled handshake ends the run as a hard failure.
      if (wait_st && !moving) begin
        if (tmo_hit) begin
          state          <= DONE;
          tmo_cnt        <= '0;
          bist_busy      <= 1'b0;
          bist_done      <= 1'b1;
          bist_pass      <= 1'b0;
          err_count      <= 16'hFFFF;
          first_err_addr <= mem_address;
          write_enable   <= 1'b0;
          read_enable    <= 1'b0;
          timeout_err    <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end else begin
        tmo_cnt <= '0;
      end
`endif
    end
  end

endmodule
